bcd_digit_editor: RTL

Parametrised successor to the 4-digit clock/alarm keyboard editor. It edits a packed BCD value of DIGITS digits, one digit at a time, using four debounced keys supplied by key_filter instances: increment, decrement, digit select and confirm.
- Each digit has its own upper limit and wraps at both ends.
- An idle timeout abandons an edit.
- Auto-repeat while a key is held is optional.
- It sits between the key_filter instances and the time/alarm registers of the digital clock.

---
 rtl/bcd_digit_editor.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_digit_editor.sv
// bcd_digit_editor: key-driven editor for a packed BCD value, one digit at a time.
// Latency: every key, load or enable action is visible one clock after it is sampled.
// Backpressure: none; key flags are single-cycle events that are acted on or dropped.
//
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat of a held inc/dec key).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   en                       editing enable; low abandons an edit and blocks entry
//   load, data_in            overwrite the committed value (and shadow) directly
//   key_{inc,dec,sel,ok}_*   key_filter outputs: change pulse (_flag) and level (_state, 0 = pressed)
//   data_out, data_out_vld   committed value and its one-cycle commit pulse
//   editing                  high while an edit is in progress
//   digit_sel                one-hot active digit (MSB = bit DIGITS-1), zero when not editing

module bcd_digit_editor #(
  parameter int unsigned         DIGITS        = 4,
  parameter logic [4*DIGITS-1:0] DIGIT_MAX     = 16'h5959,
  parameter int unsigned         TIMEOUT       = 250_000_000,
  parameter int unsigned         REPEAT_DELAY  = 25_000_000,
  parameter int unsigned         REPEAT_PERIOD = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  key_inc_flag,
  input  logic                  key_inc_state,
  input  logic                  key_dec_flag,
  input  logic                  key_dec_state,
  input  logic                  key_sel_flag,
  input  logic                  key_sel_state,
  input  logic                  key_ok_flag,
  input  logic                  key_ok_state,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  data_out_vld,
  output logic                  editing,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [DIGITS-1:0] SEL_MSB = DIGITS'(1) << (DIGITS - 1);

  typedef enum logic {IDLE, EDIT} state_t;

  state_t                state_q, state_nxt;
  logic [4*DIGITS-1:0]   shadow_q, shadow_step;
  logic [4*DIGITS-1:0]   data_out_q;
  logic                  vld_q;
  logic [DIGITS-1:0]     sel_q, sel_rot;
  logic [TO_W-1:0]       to_cnt_q;

  // Press events only; release events (flag with state high) are ignored here.
  logic inc_press, dec_press, sel_press, ok_press;
  assign inc_press = key_inc_flag & ~key_inc_state;
  assign dec_press = key_dec_flag & ~key_dec_state;
  assign sel_press = key_sel_flag & ~key_sel_state;
  assign ok_press  = key_ok_flag  & ~key_ok_state;

  logic is_edit;
  assign is_edit = (state_q == EDIT);

  // Cycles where the edit continues and the inc/dec slot is not pre-empted by
  // a higher-priority event.
  logic step_slot;
  assign step_slot = is_edit & ~load & en & ~ok_press & ~sel_press;

  logic rep_fire;  // auto-repeat step this cycle
  logic rep_up;    // direction of that step: 1 = increment

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic             rep_vld_q;    // a single key is being tracked since its press
  logic             rep_dir_q;    // tracked key: 1 = inc, 0 = dec
  logic             rep_first_q;  // still waiting for the initial delay
  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_held, rep_other_up, rep_live, rep_wrap, stay_edit;

  assign rep_held     = rep_dir_q ? ~key_inc_state : ~key_dec_state;
  assign rep_other_up = rep_dir_q ?  key_dec_state :  key_inc_state;
  // A fresh inc/dec press restarts (or cancels) tracking instead of stepping twice.
  assign rep_live     = is_edit & rep_vld_q & rep_held & rep_other_up & ~inc_press & ~dec_press;
  assign rep_wrap     = (rep_cnt_q == (rep_first_q ? REP_DLY_LAST : REP_PER_LAST));
  assign rep_fire     = rep_live & rep_wrap;
  assign rep_up       = rep_dir_q;
  assign stay_edit    = is_edit & (state_nxt == EDIT);

  always_ff @(posedge clk) begin
    if (rst || !stay_edit) begin
      rep_vld_q   <= 1'b0;
      rep_dir_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else if (inc_press || dec_press) begin
      // Arm only for a lone press that actually stepped the digit and whose
      // partner key is not already held.
      rep_vld_q   <= step_slot & (inc_press ^ dec_press) &
                     (inc_press ? key_dec_state : key_inc_state);
      rep_dir_q   <= inc_press;
      rep_first_q <= 1'b1;
      rep_cnt_q   <= '0;
    end else if (!rep_live) begin
      rep_vld_q   <= 1'b0;
    end else if (rep_wrap) begin
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
  assign rep_up   = 1'b0;
`endif

  logic step_evt, step_inc, step_dec, timeout_hit;
  assign step_evt    = inc_press | dec_press | rep_fire;
  // Simultaneous inc and dec presses cancel each other but still count as activity.
  assign step_inc    = (inc_press & ~dec_press) | (~inc_press & ~dec_press & rep_fire & rep_up);
  assign step_dec    = (dec_press & ~inc_press) | (~inc_press & ~dec_press & rep_fire & ~rep_up);
  assign timeout_hit = (to_cnt_q == TO_LAST) & ~step_evt;

  function automatic logic [3:0] digit_up(input logic [3:0] d, input logic [3:0] mx);
    return (d >= mx) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_down(input logic [3:0] d, input logic [3:0] mx);
    return ((d == 4'd0) || (d > mx)) ? mx : d - 4'd1;
  endfunction

  // Only the selected digit moves; all others pass through untouched.
  always_comb begin
    shadow_step = shadow_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) begin
        if (step_inc) begin
          shadow_step[4*i +: 4] = digit_up(shadow_q[4*i +: 4], DIGIT_MAX[4*i +: 4]);
        end else if (step_dec) begin
          shadow_step[4*i +: 4] = digit_down(shadow_q[4*i +: 4], DIGIT_MAX[4*i +: 4]);
        end
      end
    end
  end

  // Rotate one place toward the LSB, wrapping from the LSB back to the MSB.
  assign sel_rot = (sel_q >> 1) | (DIGITS'(sel_q[0]) << (DIGITS - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: begin
        if (!load && en && sel_press) begin
          state_nxt = EDIT;
        end
      end
      EDIT: begin
        if (load || !en || ok_press) begin
          state_nxt = IDLE;
        end else if (!sel_press && timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    editing      = is_edit;
    digit_sel    = is_edit ? sel_q : '0;
    data_out     = data_out_q;
    data_out_vld = vld_q;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      shadow_q   <= '0;
      vld_q      <= 1'b0;
      sel_q      <= '0;
      to_cnt_q   <= '0;
    end else begin
      vld_q <= 1'b0;
      if (load) begin
        data_out_q <= data_in;
        shadow_q   <= data_in;
        sel_q      <= '0;
        to_cnt_q   <= '0;
      end else if (!is_edit) begin
        to_cnt_q <= '0;
        if (en && sel_press) begin
          shadow_q <= data_out_q;
          sel_q    <= SEL_MSB;
        end
      end else if (!en) begin
        sel_q    <= '0;
        to_cnt_q <= '0;
      end else if (ok_press) begin
        data_out_q <= shadow_q;
        vld_q      <= 1'b1;
        sel_q      <= '0;
        to_cnt_q   <= '0;
      end else if (sel_press) begin
        sel_q    <= sel_rot;
        to_cnt_q <= '0;
      end else if (step_evt) begin
        shadow_q <= shadow_step;
        to_cnt_q <= '0;
      end else if (timeout_hit) begin
        // Abandon: data_out stays, shadow is reloaded on the next entry.
        sel_q    <= '0;
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

endmodule
